// File: rtl/multi_cycle_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration loop and reports Q=all ones, R=dividend.
module multi_cycle_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_idx;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (B1 == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operands stay untouched during RUN; the dividend bit is picked by index instead of shifting.
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_idx   = CW'(WIDTH - 1) - r_cnt;
    assign w_shift = {r_rem, r_a[w_idx]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    // When w_ge holds the true difference is below r_b, so WIDTH bits suffice.
    assign w_diff     = w_shift[WIDTH-1:0] - r_b;
    assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];

    always_comb begin
        w_q_next        = r_q;
        w_q_next[w_idx] = w_ge;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A1;
            r_b   <= B1;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            if (B1 == '0) begin
                Q           <= '1;
                R           <= A1;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                Q           <= w_q_next;
                R           <= w_rem_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_divider.sv
// Directed and randomized checks of multi_cycle_divider against a quotient/remainder scoreboard.
module tb_multi_cycle_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A1;
    logic [15:0] B1;
    logic [15:0] Q;
    logic [15:0] R;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_cycle_divider #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A1         (A1),
        .B1         (B1),
        .Q          (Q),
        .R          (R),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 16'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        start = 1'b1;
        A1    = a;
        B1    = b;
        @(negedge clk);
        start = 1'b0;
        A1    = 16'($urandom);
        B1    = 16'($urandom);
    endtask

    task automatic collect(input int exp_busy);
        int          busy_n  = 0;
        int          waited  = 0;
        bit          changed = 1'b0;
        logic [15:0] q0      = Q;
        logic [15:0] r0      = R;
        exp_t        e;
        while (done !== 1'b1 && waited < 64) begin
            if (busy === 1'b1) busy_n++;
            if (Q !== q0 || R !== r0) changed = 1'b1;
            @(negedge clk);
            waited++;
        end
        check("done_seen", done, 1);
        check("busy_cycles", busy_n, exp_busy);
        check("qr_hold_in_run", changed, 0);
        check("busy_in_done", busy, 0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("Q", Q, e.q);
            check("R", R, e.r);
            check("div_by_zero", div_by_zero, e.dbz);
            if (e.b != 16'd0) begin
                check("identity", 32'(Q) * 32'(e.b) + 32'(R), 32'(e.a));
                check("r_lt_b", R < e.b, 1);
            end
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int   quiet_bad;
        logic [15:0] ra;
        logic [15:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        A1    = '0;
        B1    = '0;
        #1;
        check("rst_Q", Q, 0);
        check("rst_R", R, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(16'd100, 16'd7);
        collect(16);
        issue(16'd65535, 16'd1);
        collect(16);
        issue(16'd5, 16'd9);
        collect(16);
        issue(16'd40000, 16'd40000);
        collect(16);
        issue(16'd1234, 16'd0);
        collect(0);

        // start pulsed at RUN cycle 5 must be ignored
        issue(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        A1    = 16'd9;
        B1    = 16'd3;
        @(negedge clk);
        start = 1'b0;
        collect(11);
        issue(16'd9, 16'd3);
        collect(16);

        // asynchronous reset at RUN cycle 8
        issue(16'd100, 16'd7);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_busy", busy, 0);
        check("midrun_done", done, 0);
        check("midrun_Q", Q, 0);
        check("midrun_R", R, 0);
        check("midrun_dbz", div_by_zero, 0);
        sb.delete();
        start = 1'b1;
        A1    = 16'd77;
        B1    = 16'd1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        quiet_bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        check("no_done_after_abort", quiet_bad, 0);
        issue(16'd50, 16'd6);
        collect(16);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if (i == 3) rb = 16'd1;
            if (i == 4) rb = 16'hFFFF;
            issue(ra, rb);
            collect((rb == 16'd0) ? 0 : 16);
        end

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_cycle_divider.md
MULTI_CYCLE_DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, 16, operand, quotient and remainder width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a division; sampled on rising clk.
REQ-005 Port: A1  input  WIDTH  unsigned dividend; sampled only when start is accepted.
REQ-006 Port: B1  input  WIDTH  unsigned divisor; sampled only when start is accepted.
REQ-007 Port: Q  output  WIDTH  registered quotient.
REQ-008 Port: R  output  WIDTH  registered remainder.
REQ-009 Port: busy  output  1  high while a division is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; Q/R/div_by_zero valid.
REQ-011 Port: div_by_zero  output  1  result flag; high when the captured divisor was 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted: A1/B1 captured into internal registers; next state RUN (B1!=0) or DONE (B1==0).
REQ-014 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change until the next accepted start.
REQ-015 A1/B1 SHALL have no effect on the operation except when start is accepted.
REQ-016 RUN SHALL perform restoring division, one quotient bit per cycle, MSB first; WIDTH iterations exactly.
REQ-017 Each iteration: partial remainder (WIDTH+1 bits) shifted left one bit with the next dividend bit brought in; divisor subtracted; on non-negative result, keep difference and set quotient bit to 1; otherwise restore and set the bit to 0.
REQ-018 After the WIDTH-th iteration the FSM SHALL enter DONE; Q and R SHALL be loaded on that same edge.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-021 Latency: start accepted at edge k with nonzero divisor -> done high during the cycle after edge k+WIDTH (k+16 at default); busy high after edges k..k+15.
REQ-022 Divide by zero: start accepted at edge k with B1=0 -> done high during the cycle after edge k; Q=all ones, R=A1, div_by_zero=1; busy stays 0.
REQ-023 Nonzero divisor: div_by_zero SHALL be 0 when Q/R are loaded.
REQ-024 Q, R and div_by_zero SHALL hold their last values until the next result load; they SHALL NOT change during RUN.
REQ-025 Result SHALL satisfy A1 = Q*B1 + R with R < B1 for every nonzero B1, including A1 < B1 (Q=0, R=A1) and A1 = B1 (Q=1, R=0).
REQ-026 Arithmetic SHALL be unsigned throughout; no signed interpretation of any input.

Reset
REQ-027 rst=1 SHALL immediately, regardless of clk, force state IDLE, Q=0, R=0, busy=0, done=0, div_by_zero=0, and clear internal operand, partial-remainder and iteration-counter registers.
REQ-028 Reset asserted mid-RUN SHALL abort the division; no done pulse SHALL follow.
REQ-029 start=1 while rst=1 SHALL be ignored; the first start accepted is the first one sampled on an edge with rst=0.

Verification
REQ-030 A1=100, B1=7, start 1 cycle -> busy 16 cycles, then done pulse 1 cycle; Q=14, R=2, div_by_zero=0.
REQ-031 A1=65535, B1=1 -> Q=65535, R=0; A1=5, B1=9 -> Q=0, R=5; A1=B1=40000 -> Q=1, R=0.
REQ-032 A1=1234, B1=0 -> done in the cycle after acceptance, busy never 1; Q=16'hFFFF, R=1234, div_by_zero=1.
REQ-033 A1=100/B1=7 started, then start with A1=9/B1=3 pulsed at RUN cycle 5 -> ignored; result Q=14, R=2; next start from IDLE gives Q=3, R=0.
REQ-034 rst asserted mid-RUN at cycle 8 -> busy/done/Q/R drop to 0 immediately, no done pulse; start after release (A1=50, B1=6) -> Q=8, R=2.
REQ-035 Randomized back-to-back operations, start issued on the first IDLE cycle after each done: every result checked against A1 = Q*B1 + R, R < B1.
